i2c_reg_ctrl: RTL and testbench
===============================

Name: i2c_reg_ctrl

Overview:
Synthesizable I2C master that performs single-byte register writes and reads on a slave at a fixed 7-bit device ID. A host issues commands over a valid/ready interface and gets one response per command.
The block sequences START, device byte, register address, data, ACK/NAK, repeated START and STOP on SCL/SDA. SDA is open-drain; the top level instantiates the tristate.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency
I2C_FREQ_HZ, 100_000, SCL frequency
DEV_ID, 7'h1E, slave address; write byte = {DEV_ID,0} = 8'h3C, read byte = {DEV_ID,1} = 8'h3D

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_rw  in  1  0 = write, 1 = read
cmd_addr  in  8  register address
cmd_wdat  in  8  write data (ignored on read)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdat  out  8  read data, held until the next rsp_valid
rsp_err  out  1  slave NAK seen; qualified by rsp_valid
scl  out  1  SCL, push-pull
sda_o  out  1  SDA output value, constant 0
sda_oe  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  SDA pin sampled value

Behaviour:
- Reset values: scl=1, sda_oe=0, cmd_ready=0, rsp_valid=0, rsp_rdat=0, rsp_err=0. cmd_ready rises on the first clk after reset release.
- Asserting rst_n mid-transfer releases the bus immediately. No STOP is generated.
- Quarter tick:
  - QTR = CLK_FREQ_HZ/(4*I2C_FREQ_HZ), clamped to a minimum of 1.
  - Each bit slot is 4 quarters, each QTR clk long.
- Data bit (SCL,SDA): Q0 SCL=0 and SDA updated; Q1 SCL=0; Q2 SCL=1; Q3 SCL=1.
- Receive bits (ACK, read data): SDA released; sda_i sampled on the first clk of Q3.
- START and repeated START, (SCL,SDA) per quarter: (0,1),(1,1),(1,0),(0,0).
- STOP, per quarter: (0,0),(1,0),(1,1),(1,1).
- GAP: 4 quarters with the bus idle (1,1).
- Acceptance: on cmd_valid && cmd_ready, latch cmd_rw, cmd_addr and cmd_wdat. cmd_ready drops the next cycle. Accept cycle = cycle 0; first quarter starts at cycle 1.
- State machine: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NAK, STOP, GAP. A 2-bit byte index selects the next TX byte.
- Write sequence: START, TX 8'h3C, ACK, TX addr, ACK, TX wdat, ACK, STOP, GAP. Total 30 slots.
- Read sequence: START, TX 8'h3C, ACK, TX addr, ACK, RSTART, TX 8'h3D, ACK, RX 8 bits MSB first, TX_NAK (SDA=1), STOP, GAP. Total 40 slots.
- Bytes are transmitted MSB first. A 3-bit counter wraps 7 to 0 at the byte end.
- Any ACK sampled as 1: set rsp_err=1 and go straight to STOP, skipping the remaining bytes. On a read that aborts, rsp_rdat keeps its previous value.
- rsp_valid pulses in the clk that GAP ends, which is cycle 1 + slots*4*QTR. The state returns to IDLE on the same edge, so cmd_ready rises one cycle after rsp_valid.
- cmd_valid during a transfer is ignored. cmd_valid asserted at the same edge rsp_valid pulses is not accepted until cmd_ready is high.
- Every SDA change happens while SCL=0, except the START/STOP quarters.

Optional Feature:
Macro I2C_CLK_STRETCH_EN.
- Defined: adds input port scl_i (SCL pin sample). The divider stalls on the first clk of Q2 until scl_i==1, then Q2 and Q3 run the full QTR each.
- Not defined: no scl_i port; quarters advance purely on the tick.

Decomposition:
- Package i2c_pkg:
  - state enum
  - QUARTER encodings for START/STOP as 2-bit (SCL,SDA) constants
  - RW_WRITE/RW_READ constants
  - function f_qtr(clk_hz, i2c_hz) with the clamp
- Sub-module i2c_qtr_tick:
  - parameter QTR
  - inputs clk, rst_n, en, stall
  - outputs qtr_end pulse and 2-bit quarter index

Test Plan:
- CLK_FREQ_HZ=4_000_000 (QTR=10); write addr=8'h07, wdat=8'h21, slave ACKs all → SDA bytes 3C,07,21; rsp_valid at cycle 1201; rsp_err=0.
- Read addr=8'h07, slave returns 8'h21 → bytes 3C,07, repeated START, 3D, master NAK; rsp_valid at cycle 1601; rsp_rdat=8'h21; rsp_err=0.
- Slave NAKs the device byte on a write → STOP immediately after the 9th bit; rsp_valid at cycle 1+(1+9+1+1)*40=481; rsp_err=1.
- Back-to-back commands with cmd_valid held high → second START no earlier than 4 quarters after the first STOP; cmd_ready low throughout each transfer.
- rst_n pulsed low mid-TX_BYTE → next clk scl=1, sda_oe=0, cmd_ready=0; cmd_ready=1 one cycle after release.
- I2C_CLK_STRETCH_EN defined, scl_i held low for 25 clk in Q2 of bit 3 → that slot lengthens by exactly 25 cycles and the data is unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access master: FSM state codes,
// (SCL,SDA) quarter patterns for START/STOP, transfer direction codes and
// the quarter-period helper used to size the bit-slot divider.
package i2c_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE    = 4'd0;
   localparam state_t ST_START   = 4'd1;
   localparam state_t ST_TX_BYTE = 4'd2;
   localparam state_t ST_RX_ACK  = 4'd3;
   localparam state_t ST_RSTART  = 4'd4;
   localparam state_t ST_RX_BYTE = 4'd5;
   localparam state_t ST_TX_NAK  = 4'd6;
   localparam state_t ST_STOP    = 4'd7;
   localparam state_t ST_GAP     = 4'd8;

   // (SCL,SDA) per quarter
   localparam logic [1:0] START_Q0 = 2'b01;
   localparam logic [1:0] START_Q1 = 2'b11;
   localparam logic [1:0] START_Q2 = 2'b10;
   localparam logic [1:0] START_Q3 = 2'b00;
   localparam logic [1:0] STOP_Q0  = 2'b00;
   localparam logic [1:0] STOP_Q1  = 2'b10;
   localparam logic [1:0] STOP_Q2  = 2'b11;
   localparam logic [1:0] STOP_Q3  = 2'b11;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // Quarter-period length in system clocks, never below one clock.
   function automatic int f_qtr(input int clk_hz, input int i2c_hz);
      int q;
      q = clk_hz / (4 * i2c_hz);
      if (q < 1) q = 1;
      return q;
   endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-period divider. A down-counter loads QTR-1 and pulses qtr_end at
// terminal count; the 2-bit quarter index advances on every pulse. While en is
// low the divider is parked at the start of quarter 0. stall freezes it.
module i2c_qtr_tick #(
   parameter int QTR = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       stall,
   output logic       qtr_end,
   output logic       qtr_first,
   output logic [1:0] qtr_idx
);

   localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(QTR - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;

   assign qtr_end   = en && !stall && (cnt_q == '0);
   assign qtr_first = (cnt_q == CNT_LOAD);
   assign qtr_idx   = idx_q;

   // next count / quarter index
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en) begin
         cnt_d = CNT_LOAD;
         idx_d = 2'd0;
      end else if (!stall) begin
         if (cnt_q == '0) begin
            cnt_d = CNT_LOAD;
            idx_d = idx_q + 2'd1;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   // divider registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CNT_LOAD;
         idx_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C master for single-byte register writes/reads at a fixed device ID.
// Optional macro I2C_CLK_STRETCH_EN adds scl_i and lets a slave stretch the
// high phase: the divider holds on the first clock of Q2 until scl_i reads 1.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus idle, cmd_ready high (one cycle after returning here)
// START    | START condition slot
// TX_BYTE  | shift out byte selected by byte index, MSB first
// RX_ACK   | release SDA, sample slave ACK; NAK aborts to STOP
// RSTART   | repeated START before the read device byte
// RX_BYTE  | release SDA, shift in read data MSB first
// TX_NAK   | master NAK (SDA released) after the read byte
// STOP     | STOP condition slot
// GAP      | one idle slot; rsp_valid pulses as it ends
module i2c_reg_ctrl
   import i2c_pkg::*;
#(
   parameter int         CLK_FREQ_HZ = 50_000_000,
   parameter int         I2C_FREQ_HZ = 100_000,
   parameter logic [6:0] DEV_ID      = 7'h1E
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdat,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdat,
   output logic       rsp_err,
   output logic       scl,
   output logic       sda_o,
   output logic       sda_oe,
`ifdef I2C_CLK_STRETCH_EN
   input  logic       scl_i,
`endif
   input  logic       sda_i
);

   localparam int QTR = f_qtr(CLK_FREQ_HZ, I2C_FREQ_HZ);

   state_t      state_q, state_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  bit_q, bit_d;
   logic        rw_q, rw_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdat_q, wdat_d;
   logic        ack_q, ack_d;
   logic [7:0]  rx_q, rx_d;
   logic        err_q, err_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdat_q, rsp_rdat_d;
   logic        rsp_err_q, rsp_err_d;

   logic        qtr_end, qtr_first, stall;
   logic [1:0]  qtr_idx;
   logic        slot_end, sample, accept, ack_now;
   logic [7:0]  tx_byte;
   logic        tx_bit;
   logic [1:0]  bus;

   i2c_qtr_tick #(.QTR(QTR)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state_q != ST_IDLE),
      .stall     (stall),
      .qtr_end   (qtr_end),
      .qtr_first (qtr_first),
      .qtr_idx   (qtr_idx)
   );

`ifdef I2C_CLK_STRETCH_EN
   assign stall = (qtr_idx == 2'd2) && qtr_first && !scl_i;
`else
   assign stall = 1'b0;
`endif

   assign slot_end = qtr_end && (qtr_idx == 2'd3);
   // with QTR=1 the sample clock is also the slot-end clock
   assign sample   = (state_q != ST_IDLE) && (qtr_idx == 2'd3) && qtr_first;
   assign ack_now  = sample ? sda_i : ack_q;
   assign accept   = cmd_valid && cmd_ready_q;

   // byte to transmit for the current byte index
   always_comb begin
      tx_byte = addr_q;
      case (byte_idx_q)
         2'd0:    tx_byte = {DEV_ID, 1'b0};
         2'd1:    tx_byte = addr_q;
         default: tx_byte = (rw_q == RW_READ) ? {DEV_ID, 1'b1} : wdat_q;
      endcase
   end

   assign tx_bit = tx_byte[3'd7 - bit_q];

   // sequencing and response generation
   always_comb begin
      state_d     = state_q;
      byte_idx_d  = byte_idx_q;
      bit_d       = bit_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdat_d      = wdat_q;
      ack_d       = ack_q;
      rx_d        = rx_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      rsp_rdat_d  = rsp_rdat_q;
      rsp_err_d   = rsp_err_q;
      cmd_ready_d = (state_q == ST_IDLE) && !accept;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_START;
               byte_idx_d = 2'd0;
               bit_d      = 3'd0;
               err_d      = 1'b0;
               rw_d       = cmd_rw;
               addr_d     = cmd_addr;
               wdat_d     = cmd_wdat;
            end
         end
         ST_START, ST_RSTART: begin
            if (slot_end) state_d = ST_TX_BYTE;
         end
         ST_TX_BYTE: begin
            if (slot_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_RX_ACK;
            end
         end
         ST_RX_ACK: begin
            if (sample) ack_d = sda_i;
            if (slot_end) begin
               if (ack_now) begin
                  err_d   = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  case (byte_idx_q)
                     2'd0: begin
                        byte_idx_d = 2'd1;
                        state_d    = ST_TX_BYTE;
                     end
                     2'd1: begin
                        byte_idx_d = 2'd2;
                        state_d    = (rw_q == RW_READ) ? ST_RSTART : ST_TX_BYTE;
                     end
                     default: begin
                        state_d = (rw_q == RW_READ) ? ST_RX_BYTE : ST_STOP;
                     end
                  endcase
               end
            end
         end
         ST_RX_BYTE: begin
            if (sample) rx_d = {rx_q[6:0], sda_i};
            if (slot_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_TX_NAK;
            end
         end
         ST_TX_NAK: begin
            if (slot_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (slot_end) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (slot_end) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               if ((rw_q == RW_READ) && !err_q) rsp_rdat_d = rx_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // (SCL,SDA) drive decode; SDA value 1 means released
   always_comb begin
      bus = 2'b11;
      case (state_q)
         ST_START, ST_RSTART: begin
            case (qtr_idx)
               2'd0:    bus = START_Q0;
               2'd1:    bus = START_Q1;
               2'd2:    bus = START_Q2;
               default: bus = START_Q3;
            endcase
         end
         ST_STOP: begin
            case (qtr_idx)
               2'd0:    bus = STOP_Q0;
               2'd1:    bus = STOP_Q1;
               2'd2:    bus = STOP_Q2;
               default: bus = STOP_Q3;
            endcase
         end
         ST_TX_BYTE:                        bus = {qtr_idx[1], tx_bit};
         ST_RX_ACK, ST_RX_BYTE, ST_TX_NAK:  bus = {qtr_idx[1], 1'b1};
         default:                           bus = 2'b11;
      endcase
   end

   assign scl       = bus[1];
   assign sda_oe    = ~bus[0];
   assign sda_o     = 1'b0;
   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdat  = rsp_rdat_q;
   assign rsp_err   = rsp_err_q;

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         byte_idx_q  <= 2'd0;
         bit_q       <= 3'd0;
         rw_q        <= RW_WRITE;
         addr_q      <= 8'h00;
         wdat_q      <= 8'h00;
         ack_q       <= 1'b0;
         rx_q        <= 8'h00;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdat_q  <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_idx_q  <= byte_idx_d;
         bit_q       <= bit_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdat_q      <= wdat_d;
         ack_q       <= ack_d;
         rx_q        <= rx_d;
         err_q       <= err_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdat_q  <= rsp_rdat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl. A transaction model builds the expected list of bit
// slots (START, bits, ACK, STOP, GAP) from the command and slave behaviour,
// drives the slave side of SDA from it and checks SCL/SDA every cycle.
// Optional macro I2C_CLK_STRETCH_EN enables the clock-stretch scenario.
module tb_i2c_reg_ctrl;

   localparam int CLK_HZ = 4_000_000;
   localparam int I2C_HZ = 100_000;
   localparam int QTR    = 10;
   localparam int SLOT   = 4 * QTR;

   localparam int K_BIT = 0, K_START = 1, K_STOP = 2, K_GAP = 3;

   typedef struct {
      int   kind;
      logic mval;
      logic sval;
   } slot_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_wdat = 8'h00;
   logic       cmd_ready, rsp_valid, rsp_err, scl, sda_o, sda_oe, sda_i;
   logic [7:0] rsp_rdat;
   logic       slave_bit = 1'b1;

   assign sda_i = ~sda_oe & slave_bit;

`ifdef I2C_CLK_STRETCH_EN
   logic hold_low = 1'b0;
   logic scl_i;
   assign scl_i = scl & ~hold_low;
`endif

   always #5 clk = ~clk;

   i2c_reg_ctrl #(.CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ), .DEV_ID(7'h1E)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rw    (cmd_rw),
      .cmd_addr  (cmd_addr),
      .cmd_wdat  (cmd_wdat),
      .rsp_valid (rsp_valid),
      .rsp_rdat  (rsp_rdat),
      .rsp_err   (rsp_err),
      .scl       (scl),
      .sda_o     (sda_o),
      .sda_oe    (sda_oe),
`ifdef I2C_CLK_STRETCH_EN
      .scl_i     (scl_i),
`endif
      .sda_i     (sda_i)
   );

   int         tests = 0;
   int         fails = 0;
   slot_t      slots[$];
   logic       mon_bits[$];
   bit         mon_en = 1'b0;
   logic [7:0] mdl_rdat = 8'h00;

   // SDA seen by a slave at each SCL rising edge
   always @(posedge scl) if (mon_en) mon_bits.push_back(sda_i);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_slot(input int k, input logic m, input logic s);
      slot_t e;
      e.kind = k; e.mval = m; e.sval = s;
      slots.push_back(e);
   endtask

   task automatic push_byte(input logic [7:0] b, input logic nak);
      for (int i = 7; i >= 0; i--) push_slot(K_BIT, b[i], 1'b1);
      push_slot(K_BIT, 1'b1, nak);
   endtask

   // nak_at: which slave ACK (0..2) answers NAK, 3 = none
   task automatic build(input logic rw, input logic [7:0] addr, input logic [7:0] wdat,
                        input logic [7:0] rdat, input int nak_at, output bit err);
      slots.delete();
      err = 1'b0;
      push_slot(K_START, 1'b1, 1'b1);
      push_byte(8'h3C, nak_at == 0);
      err = (nak_at == 0);
      if (!err) begin
         push_byte(addr, nak_at == 1);
         err = (nak_at == 1);
      end
      if (!err) begin
         if (!rw) begin
            push_byte(wdat, nak_at == 2);
            err = (nak_at == 2);
         end else begin
            push_slot(K_START, 1'b1, 1'b1);
            push_byte(8'h3D, nak_at == 2);
            err = (nak_at == 2);
            if (!err) begin
               for (int i = 7; i >= 0; i--) push_slot(K_BIT, 1'b1, rdat[i]);
               push_slot(K_BIT, 1'b1, 1'b1);
            end
         end
      end
      push_slot(K_STOP, 1'b1, 1'b1);
      push_slot(K_GAP, 1'b1, 1'b1);
   endtask

   // expected {SCL, SDA released/high} for a slot quarter
   function automatic logic [1:0] exp_bus(input slot_t s, input int q);
      case (s.kind)
         K_START: case (q) 0: return 2'b01; 1: return 2'b11; 2: return 2'b10; default: return 2'b00; endcase
         K_STOP:  case (q) 0: return 2'b00; 1: return 2'b10; default: return 2'b11; endcase
         K_GAP:   return 2'b11;
         default: return {(q >= 2), s.mval};
      endcase
   endfunction

   function automatic logic [7:0] mon_byte(input int k);
      logic [7:0] b = 8'h00;
      for (int i = 0; i < 8; i++)
         b = {b[6:0], (k + i < mon_bits.size()) ? mon_bits[k + i] : 1'bx};
      return b;
   endfunction

   // Called at the negedge of the accept cycle (cycle 0); returns at the
   // negedge of the rsp_valid cycle. Stretch: scl_i held low for st_len
   // clocks starting at the first clock of Q2 of slot st_slot.
   task automatic run_cmd(input logic rw, input logic [7:0] addr, input logic [7:0] wdat,
                          input logic [7:0] rdat, input int nak_at, input bit hold,
                          input int st_slot, input int st_len, output int rsp_cyc);
      bit         exp_err, ready_bad;
      int         L, t, si, q, st0, bad_cyc;
      logic [1:0] e, a, bad_e, bad_a;
      build(rw, addr, wdat, rdat, nak_at, exp_err);
      if (rw && !exp_err) mdl_rdat = rdat;
      L = slots.size() * SLOT + st_len;
      st0 = st_slot * SLOT + 2 * QTR;
      check("accept_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdat = wdat;
      mon_bits.delete(); mon_en = 1'b1;
      rsp_cyc = -1; bad_cyc = -1; ready_bad = 1'b0; bad_e = 2'b00; bad_a = 2'b00;
      for (int c = 1; c <= L + 1; c++) begin
         @(negedge clk);
         if (hold) begin
            cmd_rw = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdat = 8'($urandom);
         end else cmd_valid = 1'b0;
         t = c - 1;
`ifdef I2C_CLK_STRETCH_EN
         hold_low = (st_len > 0) && (t >= st0) && (t < st0 + st_len);
`endif
         if (st_len > 0 && t >= st0) t = (t < st0 + st_len) ? st0 : t - st_len;
         if (c <= L) begin
            si = t / SLOT; q = (t % SLOT) / QTR;
            e = exp_bus(slots[si], q);
            slave_bit = slots[si].sval;
         end else begin
            e = 2'b11;
            slave_bit = 1'b1;
         end
         a = {scl, ~sda_oe};
         if ((a !== e || sda_o !== 1'b0) && bad_cyc < 0) begin
            bad_cyc = c; bad_e = e; bad_a = a;
         end
         if (cmd_ready !== 1'b0) ready_bad = 1'b1;
         if (rsp_valid === 1'b1 && rsp_cyc < 0) rsp_cyc = c;
         if (c == L + 1) begin
            check("rsp_err", rsp_err, exp_err);
            check("rsp_rdat", rsp_rdat, mdl_rdat);
         end
      end
      tests++;
      if (bad_cyc >= 0) begin
         fails++;
         $display("FAIL bus_wave: cycle %0d got scl,sda=%b expected %b", bad_cyc, bad_a, bad_e);
      end
      check("ready_low_in_xfer", ready_bad, 0);
      check("rsp_cycle", rsp_cyc, L + 1);
      mon_en = 1'b0;
   endtask

   task automatic next_cmd(input logic rw, input logic [7:0] addr, input logic [7:0] wdat,
                           input logic [7:0] rdat, input int nak_at, input bit hold,
                           input int st_slot, input int st_len, output int rsp_cyc);
      @(negedge clk);
      run_cmd(rw, addr, wdat, rdat, nak_at, hold, st_slot, st_len, rsp_cyc);
   endtask

   task automatic idle_gap(input int n);
      bit bad = 1'b0;
      cmd_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (cmd_ready !== 1'b1 || scl !== 1'b1 || sda_oe !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
      end
      check("idle_bus", bad, 0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int  rc, nak_at;
      bit  hold, prev_hold;
      logic rw;
      logic [7:0] addr, wdat, rdat;

      repeat (3) @(negedge clk);
      check("rst_scl", scl, 1);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdat", rsp_rdat, 0);
      check("rst_rsp_err", rsp_err, 0);
      rst_n = 1'b1;
      #1 check("ready_before_first_clk", cmd_ready, 0);

      // directed write, slave ACKs everything
      next_cmd(1'b0, 8'h07, 8'h21, 8'h00, 3, 1'b0, 0, 0, rc);
      check("wr_rsp_cycle_lit", rc, 1201);
      check("wr_byte0_lit", mon_byte(1), 8'h3C);
      check("wr_byte1_lit", mon_byte(10), 8'h07);
      check("wr_byte2_lit", mon_byte(19), 8'h21);
      check("wr_err_lit", rsp_err, 0);

      // directed read, slave returns 0x21
      next_cmd(1'b1, 8'h07, 8'h00, 8'h21, 3, 1'b0, 0, 0, rc);
      check("rd_rsp_cycle_lit", rc, 1601);
      check("rd_devrd_byte_lit", mon_byte(20), 8'h3D);
      check("rd_data_lit", mon_byte(29), 8'h21);
      check("rd_master_nak_lit", mon_bits[37], 1);
      check("rd_rdat_lit", rsp_rdat, 8'h21);
      check("rd_err_lit", rsp_err, 0);

      // slave NAKs the device byte on a write
      next_cmd(1'b0, 8'h55, 8'hAA, 8'h00, 0, 1'b0, 0, 0, rc);
      check("nak_rsp_cycle_lit", rc, 481);
      check("nak_err_lit", rsp_err, 1);
      check("nak_scl_rises_lit", mon_bits.size(), 11);

      // aborted read keeps the previous read data
      idle_gap(3);
      next_cmd(1'b1, 8'h10, 8'h00, 8'h5A, 1, 1'b0, 0, 0, rc);
      check("abort_rdat_kept_lit", rsp_rdat, 8'h21);

      // back-to-back with cmd_valid held high
      next_cmd(1'b0, 8'h3A, 8'hC5, 8'h00, 3, 1'b1, 0, 0, rc);
      next_cmd(1'b1, 8'h81, 8'h00, 8'h96, 3, 1'b0, 0, 0, rc);

`ifdef I2C_CLK_STRETCH_EN
      next_cmd(1'b0, 8'h07, 8'h21, 8'h00, 3, 1'b0, 4, 25, rc);
      check("stretch_rsp_cycle_lit", rc, 1226);
      check("stretch_byte1_lit", mon_byte(10), 8'h07);
      check("stretch_byte2_lit", mon_byte(19), 8'h21);
`endif

      // randomized commands
      prev_hold = 1'b0;
      for (int it = 0; it < 10; it++) begin
         rw = 1'($urandom); addr = 8'($urandom); wdat = 8'($urandom); rdat = 8'($urandom);
         nak_at = $urandom_range(0, 9);
         if (nak_at > 3) nak_at = 3;
         hold = (it < 9) && ($urandom_range(0, 1) == 1);
         if (!prev_hold) begin
            int g = $urandom_range(0, 3);
            if (g > 0) idle_gap(g);
         end
         next_cmd(rw, addr, wdat, rdat, nak_at, hold, 0, 0, rc);
         prev_hold = hold;
      end

      // reset mid TX_BYTE
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h44; cmd_wdat = 8'h99;
      @(negedge clk);
      cmd_valid = 1'b0; slave_bit = 1'b1;
      repeat (150) @(negedge clk);
      check("pre_rst_busy", cmd_ready, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_scl", scl, 1);
      check("midrst_sda_oe", sda_oe, 0);
      check("midrst_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
      check("midrst_scl_clk", scl, 1);
      check("midrst_sda_oe_clk", sda_oe, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mdl_rdat = 8'h00;
      #1 check("postrst_ready_low", cmd_ready, 0);
      check("postrst_rdat", rsp_rdat, 0);
      next_cmd(1'b1, 8'h07, 8'h00, 8'hE3, 3, 1'b0, 0, 0, rc);
      check("postrst_rsp_cycle_lit", rc, 1601);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
